// File: rtl/operand_pingpong_buffer.sv
// operand_pingpong_buffer
//
// Double-buffered operand staging memory that feeds one operand port of the
// 8x8 systolic multiplier. The loader fills one bank with a full DIM x DIM
// signed matrix, one row per beat, while the array drains the other bank one
// row (or one column when TRANSPOSE=1) per beat. Banks strictly alternate on
// both sides, so matrices leave in the order they arrived.
//
// Ports:
//   clk        - single clock, rising edge
//   rst        - asynchronous active-high reset, synchronous release
//   clear      - synchronous abort: both banks empty, pointers to 0, data kept
//   wr_valid   - loader presents a row on wr_row
//   wr_ready   - a row can be accepted this cycle
//   wr_row     - row data, element j is column j
//   rd_valid   - current read bank holds a full matrix
//   rd_ready   - consumer takes the beat on rd_data
//   rd_data    - row rrow (or column rrow when transposing), zero when idle
//   rd_last    - high with rd_valid on the final beat of a bank
//   full_count - number of banks currently full (0..2)

module operand_pingpong_buffer #(
   parameter int DATA_WIDTH = 8,
   parameter int DIM        = 8,
   parameter int TRANSPOSE  = 0
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         clear,
   input  logic                         wr_valid,
   output logic                         wr_ready,
   input  logic signed [DATA_WIDTH-1:0] wr_row [DIM],
   output logic                         rd_valid,
   input  logic                         rd_ready,
   output logic signed [DATA_WIDTH-1:0] rd_data [DIM],
   output logic                         rd_last,
   output logic [1:0]                   full_count
);

   localparam int PW = (DIM > 1) ? $clog2(DIM) : 1;
   localparam logic [PW-1:0] LAST_ROW = PW'(DIM - 1);

   logic signed [DATA_WIDTH-1:0] mem [2][DIM][DIM];
   logic [1:0]    full;
   logic          wbank;
   logic          rbank;
   logic [PW-1:0] wrow;
   logic [PW-1:0] rrow;
   logic          wr_accept;
   logic          rd_accept;

   // Handshake decode. wr_ready is forced low while reset is held so the
   // loader never sees a ready that could be lost to the reset.
   assign wr_ready   = !full[wbank] && !rst;
   assign wr_accept  = wr_valid && wr_ready;
   assign rd_valid   = full[rbank];
   assign rd_accept  = rd_valid && rd_ready;
   assign rd_last    = rd_valid && (rrow == LAST_ROW);
   assign full_count = {1'b0, full[0]} + {1'b0, full[1]};

   // Bank/pointer control. A write only ever targets a non-full bank and a
   // read only ever targets a full bank, so both sides may complete a bank
   // in the same cycle without touching the same full[] bit. clear wins over
   // any accept happening in the same cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         full  <= '0;
         wbank <= 1'b0;
         rbank <= 1'b0;
         wrow  <= '0;
         rrow  <= '0;
      end else if (clear) begin
         full  <= '0;
         wbank <= 1'b0;
         rbank <= 1'b0;
         wrow  <= '0;
         rrow  <= '0;
      end else begin
         if (wr_accept) begin
            if (wrow == LAST_ROW) begin
               full[wbank] <= 1'b1;
               wbank       <= ~wbank;
               wrow        <= '0;
            end else begin
               wrow <= wrow + 1'b1;
            end
         end
         if (rd_accept) begin
            if (rrow == LAST_ROW) begin
               full[rbank] <= 1'b0;
               rbank       <= ~rbank;
               rrow        <= '0;
            end else begin
               rrow <= rrow + 1'b1;
            end
         end
      end
   end

   // Matrix storage. Reset zeroes every element; clear deliberately leaves
   // the contents alone because a refilled bank overwrites all rows before
   // it can ever be read again.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int b = 0; b < 2; b++) begin
            for (int r = 0; r < DIM; r++) begin
               for (int c = 0; c < DIM; c++) begin
                  mem[b][r][c] <= '0;
               end
            end
         end
      end else if (wr_accept && !clear) begin
         for (int j = 0; j < DIM; j++) begin
            mem[wbank][wrow][j] <= wr_row[j];
         end
      end
   end

   // Read mux straight from the flops, so a beat is visible in the same
   // cycle rd_valid is. Transposing just swaps the row/column index; the
   // output is driven to zero whenever nothing valid is being offered.
   always_comb begin
      for (int k = 0; k < DIM; k++) begin
         rd_data[k] = '0;
         if (rd_valid) begin
            if (TRANSPOSE != 0) begin
               rd_data[k] = mem[rbank][k][rrow];
            end else begin
               rd_data[k] = mem[rbank][rrow][k];
            end
         end
      end
   end

endmodule

// File: tb/tb_operand_pingpong_buffer.sv
// tb_operand_pingpong_buffer
//
// Drives two buffer instances (row order and transposed) with identical
// stimulus and compares both against a queue-of-matrices model: full
// matrices wait in a FIFO of depth 2, a partial matrix collects incoming
// rows, and a beat counter walks the head matrix.

module tb_operand_pingpong_buffer;

   localparam int DIM = 8;
   localparam int DW  = 8;

   typedef logic [DIM*DIM*DW-1:0] mat_t;

   logic clk = 1'b0;
   bit   clk_run = 1'b1;
   logic rst;
   logic clear;
   logic wr_valid;
   logic rd_ready;
   logic signed [DW-1:0] wr_row [DIM];

   logic                 wr_ready_t0, rd_valid_t0, rd_last_t0;
   logic signed [DW-1:0] rd_data_t0 [DIM];
   logic [1:0]           full_count_t0;
   logic                 wr_ready_t1, rd_valid_t1, rd_last_t1;
   logic signed [DW-1:0] rd_data_t1 [DIM];
   logic [1:0]           full_count_t1;

   // Reference model state
   mat_t mq[$];
   mat_t part;
   int   part_rows;
   int   beat;
   bit   m_wacc, m_racc;

   int n_vec = 0;
   int n_err = 0;
   int rows_sent;
   int mode;

   operand_pingpong_buffer #(.DATA_WIDTH(DW), .DIM(DIM), .TRANSPOSE(0)) dut0 (
      .clk(clk), .rst(rst), .clear(clear),
      .wr_valid(wr_valid), .wr_ready(wr_ready_t0), .wr_row(wr_row),
      .rd_valid(rd_valid_t0), .rd_ready(rd_ready), .rd_data(rd_data_t0),
      .rd_last(rd_last_t0), .full_count(full_count_t0)
   );

   operand_pingpong_buffer #(.DATA_WIDTH(DW), .DIM(DIM), .TRANSPOSE(1)) dut1 (
      .clk(clk), .rst(rst), .clear(clear),
      .wr_valid(wr_valid), .wr_ready(wr_ready_t1), .wr_row(wr_row),
      .rd_valid(rd_valid_t1), .rd_ready(rd_ready), .rd_data(rd_data_t1),
      .rd_last(rd_last_t1), .full_count(full_count_t1)
   );

   // Free-running clock that can be frozen for the async reset check.
   initial begin
      forever begin
         #5;
         if (clk_run) clk = ~clk;
      end
   end

   function automatic int elem(input mat_t m, input int r, input int c);
      logic signed [DW-1:0] v;
      v = m[(r*DIM + c)*DW +: DW];
      return int'(v);
   endfunction

   task automatic cmp(input string name, input int act, input int exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model update: a FIFO of at most two completed matrices. Accept
   // decisions are made from the state before the edge, so a freeing read
   // and a completing write in the same cycle both take effect.
   always @(posedge clk or posedge rst) begin
      if (rst || clear) begin
         mq.delete();
         part_rows = 0;
         beat      = 0;
      end else begin
         m_wacc = wr_valid && (mq.size() < 2);
         m_racc = rd_ready && (mq.size() > 0);
         if (m_racc) begin
            if (beat == DIM-1) begin
               void'(mq.pop_front());
               beat = 0;
            end else begin
               beat++;
            end
         end
         if (m_wacc) begin
            for (int j = 0; j < DIM; j++) part[(part_rows*DIM + j)*DW +: DW] = wr_row[j];
            if (part_rows == DIM-1) begin
               mq.push_back(part);
               part_rows = 0;
            end else begin
               part_rows++;
            end
         end
      end
   end

   // Compare every output of both instances against the model.
   task automatic checkOutput();
      int  n;
      bit  v;
      int  e0, e1;
      n = mq.size();
      v = (n > 0);
      cmp("wr_ready_t0", wr_ready_t0, (!rst && n < 2) ? 1 : 0);
      cmp("wr_ready_t1", wr_ready_t1, (!rst && n < 2) ? 1 : 0);
      cmp("rd_valid_t0", rd_valid_t0, v);
      cmp("rd_valid_t1", rd_valid_t1, v);
      cmp("rd_last_t0", rd_last_t0, (v && beat == DIM-1) ? 1 : 0);
      cmp("rd_last_t1", rd_last_t1, (v && beat == DIM-1) ? 1 : 0);
      cmp("full_count_t0", full_count_t0, n);
      cmp("full_count_t1", full_count_t1, n);
      for (int k = 0; k < DIM; k++) begin
         e0 = v ? elem(mq[0], beat, k) : 0;
         e1 = v ? elem(mq[0], k, beat) : 0;
         cmp($sformatf("rd_data_t0[%0d]", k), rd_data_t0[k], e0);
         cmp($sformatf("rd_data_t1[%0d]", k), rd_data_t1[k], e1);
      end
   endtask

   always @(negedge clk) checkOutput();

   // Row generator: 0 = 8r+j ramp, 1 = alternating -128/127, else random.
   task automatic new_row();
      int r;
      r = rows_sent % DIM;
      for (int j = 0; j < DIM; j++) begin
         case (mode)
            0:       wr_row[j] = 8'(8*r + j);
            1:       wr_row[j] = (((r + j) % 2) == 0) ? -8'sd128 : 8'sd127;
            default: wr_row[j] = 8'($urandom);
         endcase
      end
   endtask

   // One clock of stimulus; the row is held until the model says it was
   // taken, then the next row is presented.
   task automatic applyStimulus(input bit wv, input bit rr, input bit clr);
      bit acc;
      wr_valid = wv;
      rd_ready = rr;
      clear    = clr;
      @(negedge clk);
      acc = wv && !clr && !rst && (mq.size() < 2);
      @(posedge clk);
      #1;
      if (acc) begin
         rows_sent++;
         new_row();
      end
   endtask

   task automatic start_matrix_stream(input int m);
      mode      = m;
      rows_sent = 0;
      new_row();
   endtask

   initial begin
      rst       = 1'b1;
      clear     = 1'b0;
      wr_valid  = 1'b0;
      rd_ready  = 1'b0;
      rows_sent = 0;
      mode      = 0;
      for (int j = 0; j < DIM; j++) wr_row[j] = '0;

      // Reset values
      applyStimulus(0, 0, 0);
      applyStimulus(0, 0, 0);
      cmp("rst_wr_ready", wr_ready_t0, 0);
      cmp("rst_full_count", full_count_t0, 0);
      cmp("rst_rd_valid", rd_valid_t0, 0);
      rst = 1'b0;
      #1;
      cmp("post_rst_wr_ready", wr_ready_t0, 1);

      // Single ramp matrix, read side always ready
      start_matrix_stream(0);
      for (int i = 0; i < DIM; i++) applyStimulus(1, 1, 0);
      cmp("t1_rd_valid", rd_valid_t0, 1);
      cmp("t1_full_count", full_count_t0, 1);
      cmp("t1_row0_d3", rd_data_t0[3], 3);
      cmp("t1_col0_d3", rd_data_t1[3], 24);
      cmp("t1_last_beat0", rd_last_t0, 0);
      for (int i = 0; i < DIM-1; i++) applyStimulus(0, 1, 0);
      cmp("t1_last_beat7", rd_last_t0, 1);
      cmp("t1_row7_d0", rd_data_t0[0], 56);
      cmp("t1_col7_d0", rd_data_t1[0], 7);
      applyStimulus(0, 1, 0);
      cmp("t1_drained", full_count_t0, 0);

      // Extreme signed values pass bit-exact
      start_matrix_stream(1);
      for (int i = 0; i < DIM; i++) applyStimulus(1, 0, 0);
      cmp("t2_row0_d0", rd_data_t0[0], -128);
      cmp("t2_row0_d1", rd_data_t0[1], 127);
      cmp("t2_col0_d1", rd_data_t1[1], 127);
      for (int i = 0; i < DIM + 2; i++) applyStimulus(0, 1, 0);

      // Backpressure: three matrices offered, reader stalled
      start_matrix_stream(2);
      for (int i = 0; i < 2*DIM + 4; i++) applyStimulus(1, 0, 0);
      cmp("t3_full_count", full_count_t0, 2);
      cmp("t3_wr_ready", wr_ready_t0, 0);
      for (int i = 0; i < DIM; i++) applyStimulus(1, 1, 0);
      cmp("t3_wr_ready_back", wr_ready_t0, 1);
      for (int i = 0; i < 40 && rows_sent < 3*DIM; i++) applyStimulus(1, 1, 0);
      cmp("t3_rows_sent", rows_sent, 3*DIM);
      for (int i = 0; i < 4*DIM; i++) applyStimulus(0, 1, 0);
      cmp("t3_drained", full_count_t0, 0);

      // Random overlap over 20 matrices
      start_matrix_stream(2);
      for (int i = 0; i < 3000 && rows_sent < 20*DIM; i++)
         applyStimulus(1'($urandom % 2), 1'($urandom % 2), 0);
      cmp("t4_rows_budget", rows_sent, 20*DIM);
      for (int i = 0; i < 200 && mq.size() > 0; i++)
         applyStimulus(1'b0, 1'($urandom % 2), 0);
      cmp("t4_drained", full_count_t0, 0);

      // clear after five rows of bank 0
      applyStimulus(0, 0, 1);
      start_matrix_stream(0);
      for (int i = 0; i < 5; i++) applyStimulus(1, 0, 0);
      applyStimulus(1, 0, 1);
      cmp("t5_full_count", full_count_t0, 0);
      cmp("t5_rd_valid", rd_valid_t0, 0);
      cmp("t5_wr_ready", wr_ready_t0, 1);
      start_matrix_stream(0);
      for (int i = 0; i < DIM; i++) applyStimulus(1, 0, 0);
      cmp("t5_row0_d5", rd_data_t0[5], 5);
      cmp("t5_col0_d2", rd_data_t1[2], 16);
      for (int i = 0; i < DIM + 2; i++) applyStimulus(0, 1, 0);

      // Async reset at read beat 3 with the clock frozen
      start_matrix_stream(2);
      for (int i = 0; i < DIM; i++) applyStimulus(1, 0, 0);
      for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0);
      rd_ready = 1'b0;
      @(negedge clk);
      #1;
      clk_run = 1'b0;
      cmp("t6_pre_valid", rd_valid_t0, 1);
      rst = 1'b1;
      #2;
      cmp("t6_rd_valid_t0", rd_valid_t0, 0);
      cmp("t6_rd_valid_t1", rd_valid_t1, 0);
      cmp("t6_rd_last", rd_last_t0, 0);
      cmp("t6_wr_ready", wr_ready_t0, 0);
      cmp("t6_full_count", full_count_t0, 0);
      for (int k = 0; k < DIM; k++) begin
         cmp($sformatf("t6_rd_data_t0[%0d]", k), rd_data_t0[k], 0);
         cmp($sformatf("t6_rd_data_t1[%0d]", k), rd_data_t1[k], 0);
      end
      #2;
      rst = 1'b0;
      #1;
      clk_run = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) applyStimulus(0, 1, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
